// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encodings and the decimal range limit live here.
package bin_to_bcd_seq_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned MAX_VAL     = 999;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StConv   = 2'd1,
    StFinish = 2'd2
  } state_e;

  // Largest value representable in `digits` decimal digits.
  function automatic int unsigned max_val(input int unsigned digits);
    int unsigned m;
    m = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      m = m * 10;
    end
    return m - 1;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the binary datapath and the BCD converter.
interface bin_to_bcd_seq_if
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
);

  logic                          start;
  logic [BIN_W-1:0]              bin_in;
  logic                          busy;
  logic                          done;
  logic                          overflow;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;

  modport master (
    output start, bin_in,
    input  busy, done, overflow, bcd_out
  );

  modport slave (
    input  start, bin_in,
    output busy, done, overflow, bcd_out
  );

endinterface

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, result held until the next done.
// Out-of-range inputs are flagged and reported as all nines.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned BIN_W  = 10,
  parameter int unsigned DIGITS = 3
) (
  input logic              i_clk,
  input logic              i_rst_n,
  bin_to_bcd_seq_if.slave  bus
);

  localparam int unsigned SCR_W  = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W  = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_V  = 32'(max_val(DIGITS));
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  state_e           r_state;
  logic [BIN_W-1:0] r_shreg;
  logic [SCR_W-1:0] r_scratch;
  logic [SCR_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf_pend;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic [SCR_W-1:0] w_adj;
  logic             w_over;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_scratch[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .o_digit (w_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign w_over = 32'(bus.bin_in) > MAX_V;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_shreg    <= '0;
      r_scratch  <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_shreg    <= bus.bin_in;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= w_over;
            r_busy     <= 1'b1;
            r_state    <= StConv;
          end
        end
        StConv: begin
          // Corrected digits and the shift register move left as one word.
          r_scratch <= {w_adj[SCR_W-2:0], r_shreg[BIN_W-1]};
          r_shreg   <= {r_shreg[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_IT) begin
            r_state <= StFinish;
          end
        end
        StFinish: begin
          r_bcd   <= r_ovf_pend ? {DIGITS{4'h9}} : r_scratch;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.bcd_out  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: stimulus pushes expected results, a monitor checks done.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  exp_t q[$];
  logic [11:0] prev_bcd = '0;
  logic        prev_done = 1'b0;

  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(3)) bus ();

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference from plain division; saturates to 999 above range.
  function automatic exp_t ref_conv(input int v);
    exp_t e;
    if (v > 999) begin
      e.bcd = 12'h999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_bcd  = '0;
      prev_done = 1'b0;
    end else begin
      if (bus.done) begin
        done_cnt++;
        chk("done_one_cycle", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: bcd_out=%0h with no pending request", bus.bcd_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("bcd_out", 32'(bus.bcd_out), 32'(e.bcd));
          chk("overflow", 32'(bus.overflow), 32'(e.ovf));
        end
      end else if (bus.bcd_out !== prev_bcd) begin
        chk("bcd_stable", 32'(bus.bcd_out), 32'(prev_bcd));
      end
      prev_bcd  = bus.bcd_out;
      prev_done = bus.done;
    end
  end

  // Drives start for one edge from the current time; caller ensures the DUT is idle.
  task automatic start_conv(input int v);
    bus.start  = 1'b1;
    bus.bin_in = 10'(v);
    q.push_back(ref_conv(v));
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = 10'($urandom);
  endtask

  // Returns edges since the accepting edge and busy samples seen; leaves time in the done cycle.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) nbusy++;
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done within %0d cycles", n);
    end else begin
      chk("busy_low_at_done", 32'(bus.busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb;
    int base;
    int vals[5] = '{0, 255, 999, 1023, 42};

    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_bcd", 32'(bus.bcd_out), 32'd0);
    chk("reset_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vals[i]) begin
      start_conv(vals[i]);
      wait_done(n, nb);
      chk("latency", 32'(n), 32'd11);
      chk("busy_cycles", 32'(nb), 32'd11);
      repeat (2) @(posedge clk);
      #1;
    end

    // Start while busy must be ignored.
    base = done_cnt;
    start_conv(37);
    repeat (3) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.bin_in = 10'd500;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, nb);
    repeat (15) @(posedge clk);
    #1;
    chk("ignored_start_dones", 32'(done_cnt - base), 32'd1);

    // Back-to-back: second start issued in the done cycle.
    start_conv(123);
    wait_done(n, nb);
    start_conv(456);
    wait_done(n, nb);
    chk("done_spacing", 32'(n + 1), 32'd12);
    repeat (2) @(posedge clk);
    #1;

    // Leave overflow and a nonzero result visible, then abort a conversion with reset.
    start_conv(1000);
    wait_done(n, nb);
    repeat (2) @(posedge clk);
    #1;
    base = done_cnt;
    start_conv(888);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd", 32'(bus.bcd_out), 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - base), 32'd0);
    start_conv(7);
    wait_done(n, nb);
    chk("latency_after_reset", 32'(n), 32'd11);

    for (int k = 0; k < 40; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(posedge clk);
      #1;
      start_conv(int'($urandom_range(0, 1023)));
      wait_done(n, nb);
      chk("rand_latency", 32'(n), 32'd11);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
